// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF input sync and centre-of-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx #(
  parameter int CLK_FREQ_KHz  = 50000,
  parameter int BAUD_RATE_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_en,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int BIT_CLOCKS = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS;
  localparam int HALF_BIT   = BIT_CLOCKS / 2;
  localparam int CW         = $clog2(BIT_CLOCKS);

  localparam logic [CW-1:0] BIT_TC  = CW'(BIT_CLOCKS - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_START   = 6'b000010,
    S_DATA    = 6'b000100,
    S_STOP    = 6'b001000,
    S_RECOVER = 6'b010000,
    S_PARITY  = 6'b100000
  } state_e;
`else
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_START   = 5'b00010,
    S_DATA    = 5'b00100,
    S_STOP    = 5'b01000,
    S_RECOVER = 5'b10000
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            data_en_q, data_en_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic            rx_s;
  logic            bit_tc;

`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
`endif

  assign rx_s   = sync_q[1];
  assign bit_tc = (cnt_q == BIT_TC);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    data_en_d   = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_tc) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tc) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_tc) begin
          cnt_d = '0;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = S_RECOVER;
`ifdef UART_RX_PARITY_EN
          end else if (^{shift_q, par_q}) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
`endif
          end else begin
            data_d    = shift_q;
            data_en_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // a stuck-low line must rise before a new start edge counts
      S_RECOVER: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], rx};
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      data_en_q   <= data_en_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_q;
  assign data_en   = data_en_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit.
// Expected bytes come from a serial-line model of the frames sent.
module tb_uart_rx;

  localparam int BIT = 8;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME = 11 * BIT;
`else
  localparam int FRAME = 10 * BIT;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       data_en;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  int         ferr_n = 0;
  int         perr_n = 0;
  bit         both_hi = 1'b0;
  logic [7:0] last_good;

  uart_rx #(
    .CLK_FREQ_KHz (1000),
    .BAUD_RATE_BPS(115200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .data_en   (data_en),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_en) begin
      got_q.push_back(data);
      got_t.push_back(cyc);
    end
    if (frame_err) ferr_n++;
    if (parity_err) perr_n++;
    if (data_en && frame_err) both_hi = 1'b1;
  end

  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input bit pflip);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ pflip;
    repeat (BIT) @(negedge clk);
`else
    if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
    rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (data !== 8'h00) begin n_bad++;
      $display("FAIL reset_data got %h want 00", data); end
    n_cmp++; if (data_en !== 1'b0) begin n_bad++;
      $display("FAIL reset_data_en got %b want 0", data_en); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_parity_err got %b want 0", parity_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    last_good = 8'h00;
    idle(4);
  endtask

  task automatic test_basic;
    int base, f0, k;
    base = got_q.size();
    f0   = ferr_n;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
    join_none
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (data_en) break;
    end
    n_cmp++; if (k >= 200) begin n_bad++;
      $display("FAIL basic_strobe got none want one in 200 clk"); end
    n_cmp++; if (data !== 8'hA5) begin n_bad++;
      $display("FAIL basic_data got %h want a5", data); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL basic_busy_at_strobe got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || data_en !== 1'b0) begin n_bad++;
      $display("FAIL basic_after got busy=%b en=%b want 0 0",
               busy, data_en); end
    idle(16);
    n_cmp++; if (got_q.size() - base !== 1) begin n_bad++;
      $display("FAIL basic_count got %0d want 1", got_q.size() - base); end
    n_cmp++; if (ferr_n - f0 !== 0) begin n_bad++;
      $display("FAIL basic_ferr got %0d want 0", ferr_n - f0); end
    last_good = 8'hA5;
  endtask

  task automatic test_glitch;
    int base, f0, bc;
    base = got_q.size();
    f0   = ferr_n;
    bc   = 0;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    n_cmp++; if (bc < 1 || bc > 6) begin n_bad++;
      $display("FAIL glitch_busy_len got %0d want 1..6", bc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL glitch_idle got busy=%b want 0", busy); end
    n_cmp++; if (got_q.size() != base || ferr_n != f0) begin n_bad++;
      $display("FAIL glitch_strobes got %0d/%0d want 0/0",
               got_q.size() - base, ferr_n - f0); end
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(12);
    n_cmp++;
    if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== 8'h3C) begin
      n_bad++;
      $display("FAIL glitch_next got n=%0d data=%h want 1 3c",
               got_q.size() - base, data);
    end
    last_good = 8'h3C;
  endtask

  task automatic test_frame_err;
    int base, f0;
    base = got_q.size();
    f0   = ferr_n;
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    n_cmp++; if (ferr_n - f0 !== 1) begin n_bad++;
      $display("FAIL ferr_count got %0d want 1", ferr_n - f0); end
    n_cmp++; if (got_q.size() != base) begin n_bad++;
      $display("FAIL ferr_no_data got %0d want 0", got_q.size() - base); end
    n_cmp++; if (data !== last_good) begin n_bad++;
      $display("FAIL ferr_data_hold got %h want %h", data, last_good); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL ferr_busy_low_line got %b want 1", busy); end
    idle(8);
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL ferr_busy_release got %b want 0", busy); end
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(12);
    n_cmp++; if (data !== 8'h7E || got_q.size() != base + 1) begin n_bad++;
      $display("FAIL ferr_next got %h n=%0d want 7e 1",
               data, got_q.size() - base); end
    last_good = 8'h7E;
  endtask

  task automatic test_back_to_back;
    int base;
    base = got_q.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(12);
    n_cmp++; if (got_q.size() - base !== 2) begin n_bad++;
      $display("FAIL b2b_count got %0d want 2", got_q.size() - base); end
    if (got_q.size() - base == 2) begin
      n_cmp++; if (got_q[base] !== 8'h00 || got_q[base+1] !== 8'hFF) begin
        n_bad++;
        $display("FAIL b2b_data got %h %h want 00 ff",
                 got_q[base], got_q[base+1]); end
      n_cmp++; if (got_t[base+1] - got_t[base] !== FRAME) begin n_bad++;
        $display("FAIL b2b_spacing got %0d want %0d",
                 got_t[base+1] - got_t[base], FRAME); end
    end
    last_good = 8'hFF;
  endtask

  task automatic test_reset_mid;
    int base, f0;
    logic [7:0] b;
    b = 8'h55;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[4];
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (data !== 8'h00 || busy !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_outputs got data=%h busy=%b want 00 0",
               data, busy); end
    n_cmp++; if (data_en !== 1'b0 || frame_err !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_strobes got en=%b ferr=%b want 0 0",
               data_en, frame_err); end
    last_good = 8'h00;
    base = got_q.size();
    f0   = ferr_n;
    idle(100);
    n_cmp++; if (got_q.size() != base || ferr_n != f0) begin n_bad++;
      $display("FAIL rstmid_quiet got %0d/%0d want 0/0",
               got_q.size() - base, ferr_n - f0); end
    send_frame(8'h55, 1'b1, 1'b0);
    idle(12);
    n_cmp++; if (data !== 8'h55 || got_q.size() != base + 1) begin n_bad++;
      $display("FAIL rstmid_next got %h n=%0d want 55 1",
               data, got_q.size() - base); end
    last_good = 8'h55;
  endtask

  task automatic test_loopback;
    int base;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    base = got_q.size();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 22; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) begin
      b = exp_q[i];
      send_frame(b, 1'b1, 1'b0);
      idle($urandom_range(0, 3) * BIT);
    end
    idle(12);
    n_cmp++; if (got_q.size() - base !== exp_q.size()) begin n_bad++;
      $display("FAIL loop_count got %0d want %0d",
               got_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base+i] !== exp_q[i]) begin n_bad++;
        $display("FAIL loop_byte%0d got %h want %h",
                 i, got_q[base+i], exp_q[i]); end
    end
    last_good = exp_q[exp_q.size()-1];
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int base, p0;
    base = got_q.size();
    p0   = perr_n;
    send_frame(8'h03, 1'b1, 1'b1);
    idle(12);
    n_cmp++; if (perr_n - p0 !== 1) begin n_bad++;
      $display("FAIL parity_err_count got %0d want 1", perr_n - p0); end
    n_cmp++; if (got_q.size() != base || data !== last_good) begin n_bad++;
      $display("FAIL parity_no_data got n=%0d data=%h want 0 %h",
               got_q.size() - base, data, last_good); end
`else
    n_cmp++; if (perr_n !== 0) begin n_bad++;
      $display("FAIL parity_tied got %0d pulses want 0", perr_n); end
`endif
    n_cmp++; if (both_hi !== 1'b0) begin n_bad++;
      $display("FAIL en_ferr_overlap got 1 want 0"); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Samples an asynchronous serial line `rx`: 8N1, LSB first, idle-high.
- Delivers each received byte as a single-cycle `data_en` strobe with `data`.
- Flags framing errors. Uses the same bit-period arithmetic as the transmitter, so the two pair directly for loopback.

Parameters:
- CLK_FREQ_KHz, 50000, system clock frequency in kHz
- BAUD_RATE_BPS, 115200, line rate in bits/s
- BIT_CLOCKS, (CLK_FREQ_KHz*1000)/BAUD_RATE_BPS, clocks per bit (derived, integer division); must be >= 4
- HALF_BIT, BIT_CLOCKS/2, clocks from start-edge detect to start-bit centre (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx  in  1  asynchronous serial input, idle high
- data  out  8  last successfully received byte; holds until the next good byte
- data_en  out  1  one-cycle strobe; `data` is valid in the same cycle
- frame_err  out  1  one-cycle strobe; stop bit sampled low
- parity_err  out  1  one-cycle strobe; parity mismatch (tied 0 unless the optional feature is enabled)
- busy  out  1  high in every state except Idle

Behaviour:
- Reset: synchronous and active-high; clock is `clk`.
  - Clears `data`=0x00, `data_en`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - State=Idle, both counters=0, shift register=0.
  - Synchronizer flops reset to 1.
  - Reset mid-frame aborts the frame immediately; no strobe is issued.
- Input sync: 2-FF synchronizer gives `rx_s`. All decisions use `rx_s` only; latency is 2 clocks from pin.
- Counters:
  - `bitClkCnt` is clog2(BIT_CLOCKS) bits, unsigned, wraps to 0 on terminal count.
  - `dataBitCnt` is 3 bits.
- States (one-hot):
  - Idle: counters=0. On `rx_s`=0 -> StartBit.
  - StartBit:
    - Count up to HALF_BIT-1.
    - At terminal, `rx_s`=0 -> DataBits with `bitClkCnt`=0.
    - At terminal, `rx_s`=1 -> glitch: Idle, no strobe.
  - DataBits:
    - Count up to BIT_CLOCKS-1; at terminal, shift `rx_s` in: shift = {rx_s, shift[7:1]} (LSB first).
    - `dataBitCnt`=7 at terminal -> `dataBitCnt`=0, go to StopBit; otherwise increment `dataBitCnt`.
  - StopBit: count up to BIT_CLOCKS-1, then sample `rx_s`:
    - `rx_s`=1 -> `data`<=shift, `data_en`<=1 for one cycle, go to Idle.
    - `rx_s`=0 -> `frame_err`<=1 for one cycle, `data` unchanged, go to Recover.
  - Recover: wait for `rx_s`=1 (break/line stuck low), then Idle. A low line never retriggers StartBit from Recover.
- Timing:
  - Strobes are registered and assert the cycle after the stop-sample edge.
  - `data_en` and `frame_err` are never high together.
- Back-to-back frames: a start edge immediately after the stop-bit sample is accepted. Idle is 1 cycle; the ~half-bit remaining in the stop bit gives margin.
- Tolerance: samples at bit centre; baud mismatch up to ±4% over a frame is accepted.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a ParityBit state between DataBits and StopBit, one BIT_CLOCKS period, sampled at the centre.
  - Even parity over the 8 data bits plus the parity bit must be 0.
  - At the stop sample:
    - Stop low -> `frame_err` (takes precedence).
    - Else parity bad -> `parity_err` one-cycle strobe, no `data_en`, `data` unchanged, go to Idle.
    - Else `data_en`.
- Undefined: 8N1 exactly as above; `parity_err` constant 0; no ParityBit state is synthesized.

Test Plan:
Benches use CLK_FREQ_KHz=1000, BAUD_RATE_BPS=115200 -> BIT_CLOCKS=8, HALF_BIT=4.
1. Drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) at 8 clk/bit -> exactly one `data_en`, `data`=0xA5, `frame_err`=0; `busy` falls the cycle after the strobe.
2. `rx` low for 2 clocks, then high -> no strobes; `busy` high for <= 6 clocks, then Idle; a following 0x3C is received correctly.
3. Frame 0x81 with stop bit low, line held low 40 clocks -> one `frame_err`, no `data_en`, `data` keeps its prior value, `busy` stays high until `rx` rises; the next frame 0x7E gives `data`=0x7E.
4. Frames 0x00 then 0xFF, each with a stop bit of exactly 8 clocks, no gap -> two `data_en` pulses, 80 clocks apart, values 0x00 then 0xFF.
5. Assert `rst` for 1 cycle during data bit 4 of 0x55 -> all outputs 0, no strobe; frame 0x55 sent afterwards is received.
6. Loopback through the team's UART transmitter (same params): send 0x5A, 0xC3 -> `data_en` twice, values 0x5A, 0xC3.
   - With UART_RX_PARITY_EN: send 0x03 with parity 1 -> `parity_err` once, no `data_en`.
